debug_regfile_tx: RTL and testbench

//  Transmit side of the CPU debug register-file port. Captures each register-file write event
//  (addr, data) as the cpu presents it and serializes it to a host as a 5-byte UART 8N1 frame.

---
 rtl/debug_defs.sv | 31 +++
 rtl/debug_trace_fifo.sv | 54 +++++
 rtl/debug_regfile_tx.sv | 151 +++++++++++++++
 tb/tb_debug_regfile_tx.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_defs.sv
// Shared definitions for the debug register-file transmit path: FSM encoding,
// frame geometry and the byte selector used to serialize one captured event.
package debug_defs;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    localparam int DBG_FRAME_BYTES = 5;
    localparam int DBG_ENTRY_W     = 37;
    localparam int UART_DATA_BITS  = 8;

    // Entry layout is {addr[4:0], data[31:0]}; byte 0 carries the address, then data MSB first.
    function automatic logic [7:0] frame_byte(input logic [DBG_ENTRY_W-1:0] entry,
                                              input logic [2:0]             idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {3'b000, entry[36:32]};
            3'd1:    b = entry[31:24];
            3'd2:    b = entry[23:16];
            3'd3:    b = entry[15:8];
            3'd4:    b = entry[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/debug_trace_fifo.sv
// Synchronous FIFO for captured write events; flush_n low empties it on the next edge.
module debug_trace_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           flush_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_en, pop_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign level    = LW'(wr_ptr_q - rd_ptr_q);
    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!flush_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (flush_n && push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/debug_regfile_tx.sv
// Captures CPU register-file write events and sends each as a 5-byte UART 8N1 frame
// ({3'b0,addr}, then data MSB byte first), buffered through a small event FIFO.
module debug_regfile_tx
    import debug_defs::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              debug_regfile_we,
    input  logic [4:0]                        debug_regfile_addr,
    input  logic [31:0]                       debug_regfile_data,
    input  logic                              clear_overflow,
    output logic                              uart_tx,
    output logic                              busy,
    output logic                              overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH+1);
    localparam int CW = $clog2(CLKS_PER_BIT);

    tx_state_e              state_q, state_d;
    logic [CW-1:0]          baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [2:0]             byte_q, byte_d;
    logic [DBG_ENTRY_W-1:0] hold_q, hold_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   overflow_q, overflow_d;

    logic                   capture, push, drop, pop, full, empty, last_baud;
    logic [DBG_ENTRY_W-1:0] rd_data;
    logic [7:0]             cur_byte;
    logic [LW-1:0]          level_next;

    // "full" is the pre-pop view, so a full FIFO drops even when the FSM pops this cycle.
    assign capture    = debug_regfile_we && (debug_regfile_addr != 5'd0);
    assign push       = capture && !full;
    assign drop       = capture && full;
    assign overflow_d = drop | (overflow_q & ~clear_overflow);
    assign level_next = fifo_level + LW'(push) - LW'(pop);
    assign busy_d     = (state_d != S_IDLE) || (level_next != '0);
    assign last_baud  = (baud_q == CW'(CLKS_PER_BIT-1));
    assign cur_byte   = frame_byte(hold_q, byte_q);

    debug_trace_fifo #(
        .WIDTH (DBG_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .flush_n   (reset),
        .push      (push),
        .push_data ({debug_regfile_addr, debug_regfile_data}),
        .pop       (pop),
        .pop_data  (rd_data),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    // tx_d is the line level for the cycle after the edge, so uart_tx comes straight from a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        hold_d  = hold_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state_q != S_IDLE) baud_d = last_baud ? '0 : baud_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    hold_d  = rd_data;
                    byte_d  = '0;
                    baud_d  = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (last_baud) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                    tx_d    = cur_byte[0];
                end
            end
            S_DATA: begin
                if (last_baud) begin
                    if (bit_q == 3'(UART_DATA_BITS-1)) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end
            end
            S_STOP: begin
                if (last_baud) begin
                    if (byte_q != 3'(DBG_FRAME_BYTES-1)) begin
                        byte_d  = byte_q + 3'd1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else if (!empty) begin
                        // Chain straight into the next frame so there is no idle gap.
                        pop     = 1'b1;
                        hold_d  = rd_data;
                        byte_d  = '0;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            hold_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            hold_q     <= hold_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign uart_tx  = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_debug_regfile_tx.sv
// Bench for debug_regfile_tx: a line-level UART receiver decodes the serial output and
// the decoded bytes are compared against frames predicted from the accepted events.
module tb_debug_regfile_tx;

    localparam int CPB      = 4;
    localparam int DEPTH    = 8;
    localparam int BYTE_CYC = 10 * CPB;
    localparam int FRAME    = 50 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] data = '0;
    logic        clear_overflow = 1'b0;
    logic        uart_tx, busy, overflow;
    logic [3:0]  fifo_level;

    debug_regfile_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .debug_regfile_we   (we),
        .debug_regfile_addr (addr),
        .debug_regfile_data (data),
        .clear_overflow     (clear_overflow),
        .uart_tx            (uart_tx),
        .busy               (busy),
        .overflow           (overflow),
        .fifo_level         (fifo_level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    // Receiver: idx 0 is the first low sample; each bit is sampled mid-period.
    logic [7:0] rx_q[$];
    int         rx_start_q[$];
    logic [7:0] exp_q[$];
    int         ferr = 0;
    bit         mon_active = 0;
    int         mon_idx, mon_start;
    logic [7:0] mon_byte;

    always @(negedge clk) begin
        if (!reset) begin
            mon_active = 0;
        end else if (!mon_active) begin
            if (uart_tx === 1'b0) begin
                mon_active = 1; mon_idx = 0; mon_start = cyc; mon_byte = '0;
            end
        end else begin
            mon_idx++;
            if (mon_idx == CPB/2 && uart_tx !== 1'b0) ferr++;
            if (mon_idx >= CPB && mon_idx < 9*CPB && (mon_idx % CPB) == CPB/2)
                mon_byte[mon_idx/CPB - 1] = uart_tx;
            if (mon_idx == 9*CPB + CPB/2 && uart_tx !== 1'b1) ferr++;
            if (mon_idx == BYTE_CYC - 1) begin
                rx_q.push_back(mon_byte);
                rx_start_q.push_back(mon_start);
                mon_active = 0;
            end
        end
    end

    task automatic nstep();
        @(negedge clk); #1;
    endtask

    task automatic clear_rx();
        rx_q.delete(); rx_start_q.delete(); exp_q.delete(); ferr = 0;
    endtask

    task automatic add_exp(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({3'b000, a});
        exp_q.push_back(d[31:24]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
    endtask

    task automatic send_event(input logic [4:0] a, input logic [31:0] d, output int wc);
        we = 1'b1; addr = a; data = d;
        nstep();
        wc = cyc;
        we = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int c = 0;
        while ((busy || mon_active) && c < maxc) begin nstep(); c++; end
        nstep();
        total++;
        if (busy || mon_active) begin
            bad++; $display("FAIL drain_timeout: busy=%0b after %0d cycles, required 0", busy, c);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; nstep(); reset = 1'b1;
        repeat (25) begin
            we = ($urandom_range(0, 3) != 0); addr = 5'($urandom); data = $urandom;
            clear_overflow = ($urandom_range(0, 7) == 0);
            nstep();
        end
        we = 1'b0; clear_overflow = 1'b0;
        reset = 1'b0;
        repeat (3) nstep();
        total += 4;
        if (uart_tx !== 1'b1)    begin bad++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (overflow !== 1'b0)   begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        if (fifo_level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        reset = 1'b1;
        repeat (5) nstep();
        total++;
        if (uart_tx !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle: tx=%b busy=%b want tx=1 busy=0", uart_tx, busy);
        end
        clear_rx();
    endtask

    task automatic test_single();
        int wc, hi;
        clear_rx();
        send_event(5'd8, 32'hDEADBEEF, wc);
        add_exp(5'd8, 32'hDEADBEEF);
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL single_tx_before: got %b want 1", uart_tx); end
        hi = 0;
        for (int k = 1; k <= FRAME; k++) begin nstep(); if (busy === 1'b1) hi++; end
        total++;
        if (hi != FRAME) begin bad++; $display("FAIL single_busy_frame: high %0d cycles want %0d", hi, FRAME); end
        nstep();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
        wait_drain(50);
        total++;
        if (rx_q.size() != 5) begin
            bad++; $display("FAIL single_len: got %0d bytes want 5", rx_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (rx_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL single_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
                end
            end
            total++;
            if (rx_start_q[0] != wc + 1) begin
                bad++; $display("FAIL single_latency: start cycle %0d want %0d", rx_start_q[0], wc + 1);
            end
        end
        total++;
        if (ferr != 0) begin bad++; $display("FAIL single_framing: errors %0d want 0", ferr); end
    endtask

    task automatic test_addr_zero();
        int wc;
        clear_rx();
        send_event(5'd0, 32'h12345678, wc);
        for (int k = 0; k < 30; k++) begin
            total++;
            if (fifo_level !== 4'd0 || busy !== 1'b0) begin
                bad++; $display("FAIL zero_ignored: level=%0d busy=%b want 0/0", fifo_level, busy);
            end
            nstep();
        end
        total++;
        if (rx_q.size() != 0) begin bad++; $display("FAIL zero_noframe: got %0d bytes want 0", rx_q.size()); end
    endtask

    task automatic test_back_to_back();
        int wc, wc0;
        logic [31:0] d;
        clear_rx();
        for (int i = 0; i < 10; i++) begin
            d = $urandom ^ (32'(i) << 28);
            send_event(5'(i + 1), d, wc);
            if (i == 0) wc0 = wc;
            if (i < DEPTH + 1) add_exp(5'(i + 1), d);
        end
        total += 2;
        if (overflow !== 1'b1) begin bad++; $display("FAIL b2b_overflow: got %b want 1", overflow); end
        if (fifo_level !== 4'(DEPTH)) begin bad++; $display("FAIL b2b_level: got %0d want %0d", fifo_level, DEPTH); end
        wait_drain(10 * FRAME);
        total++;
        if (rx_q.size() != exp_q.size()) begin
            bad++; $display("FAIL b2b_len: got %0d bytes want %0d", rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (rx_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
                end
            end
            for (int i = 1; i < rx_start_q.size(); i++) begin
                total++;
                if (rx_start_q[i] - rx_start_q[i-1] != BYTE_CYC) begin
                    bad++; $display("FAIL b2b_gap%0d: spacing %0d want %0d", i, rx_start_q[i] - rx_start_q[i-1], BYTE_CYC);
                end
            end
            total++;
            if (rx_start_q[0] != wc0 + 1) begin
                bad++; $display("FAIL b2b_first: start %0d want %0d", rx_start_q[0], wc0 + 1);
            end
        end
        total++;
        if (ferr != 0) begin bad++; $display("FAIL b2b_framing: errors %0d want 0", ferr); end
    endtask

    task automatic test_clear_overflow();
        int wc;
        reset = 1'b0; nstep(); reset = 1'b1; nstep();
        for (int i = 0; i < DEPTH + 1; i++) send_event(5'(i + 1), $urandom, wc);
        clear_overflow = 1'b1;
        send_event(5'd20, $urandom, wc);
        clear_overflow = 1'b0;
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
        clear_overflow = 1'b1; nstep(); clear_overflow = 1'b0;
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        nstep();
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_stays_clear: got %b want 0", overflow); end
        send_event(5'd21, $urandom, wc);
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_reset_again: got %b want 1", overflow); end
        reset = 1'b0; nstep(); reset = 1'b1; nstep();
        clear_rx();
    endtask

    task automatic test_reset_midframe();
        int wc, wc0;
        clear_rx();
        send_event(5'd3, 32'hA5006C3E, wc0);
        for (int i = 0; i < 3; i++) send_event(5'(10 + i), $urandom, wc);
        while (cyc < wc0 + 1 + 2*BYTE_CYC + 15) nstep();
        total++;
        if (uart_tx !== 1'b0) begin bad++; $display("FAIL mid_line_low: got %b want 0", uart_tx); end
        reset = 1'b0; nstep();
        total += 3;
        if (uart_tx !== 1'b1)    begin bad++; $display("FAIL mid_tx_high: got %b want 1", uart_tx); end
        if (fifo_level !== 4'd0) begin bad++; $display("FAIL mid_level: got %0d want 0", fifo_level); end
        if (busy !== 1'b0)       begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        reset = 1'b1;
        clear_rx();
        for (int k = 0; k < 20; k++) begin
            nstep();
            total++;
            if (uart_tx !== 1'b1) begin bad++; $display("FAIL mid_no_resume: tx=%b want 1", uart_tx); end
        end
        send_event(5'd31, 32'h0, wc);
        add_exp(5'd31, 32'h0);
        wait_drain(FRAME + 50);
        total++;
        if (rx_q.size() != 5) begin
            bad++; $display("FAIL mid_len: got %0d bytes want 5", rx_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (rx_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL mid_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
                end
            end
        end
        total++;
        if (ferr != 0) begin bad++; $display("FAIL mid_framing: errors %0d want 0", ferr); end
    endtask

    task automatic test_random();
        int wc, n;
        logic [4:0] a;
        logic [31:0] d;
        for (int r = 0; r < 3; r++) begin
            clear_rx();
            n = $urandom_range(3, 6);
            for (int i = 0; i < n; i++) begin
                a = 5'($urandom_range(0, 31)); d = $urandom;
                send_event(a, d, wc);
                if (a != 5'd0) add_exp(a, d);
                repeat ($urandom_range(0, 40)) nstep();
            end
            wait_drain(7 * FRAME);
            total += 2;
            if (overflow !== 1'b0) begin bad++; $display("FAIL rnd%0d_ovf: got %b want 0", r, overflow); end
            if (ferr != 0) begin bad++; $display("FAIL rnd%0d_framing: errors %0d want 0", r, ferr); end
            total++;
            if (rx_q.size() != exp_q.size()) begin
                bad++; $display("FAIL rnd%0d_len: got %0d bytes want %0d", r, rx_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    total++;
                    if (rx_q[i] !== exp_q[i]) begin
                        bad++; $display("FAIL rnd%0d_byte%0d: got %h want %h", r, i, rx_q[i], exp_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_addr_zero();
        test_back_to_back();
        test_clear_overflow();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
